pipe_rca_addsub: RTL
====================

# pipe_rca_addsub

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control. The n-bit operation is split into STAGES equal chunks, and one chunk is resolved per clock. Each chunk's carry is registered into the next stage, so the adder sustains one operation per cycle at n of 64 or more. It sits between operand producers and result consumers that use the team's valid/ready handshake. It is the clocked successor of the combinational n-bit RCA.

## Interface
Parameters:
- n, default 16: operand and sum width; must be ≥ 1.
- STAGES, default 4: pipeline depth; must be ≥ 1, and n % STAGES must be 0.
- W = n/STAGES (localparam): chunk width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand word present.
- in_ready  out  1  block can accept an operand word this cycle.
- A  in  n  operand A.
- B  in  n  operand B.
- C_in  in  1  carry-in.
- sub  in  1  0 selects add, 1 selects subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- S_out  out  n  sum / difference.
- C_out  out  1  carry out of the MSB.
- ovf  out  1  signed (two's-complement) overflow.

## Operation
- Effective operation:
  - sub=0: S_out = A + B + C_in.
  - sub=1: S_out = A + ~B + C_in. C_in=1 gives A−B; C_out=1 means no borrow.
- The {C_out, S_out} result is exact modulo 2^(n+1). No saturation.
- ovf = (carry into bit n−1) XOR C_out, computed in the last stage.
- Stage k (k = 0..STAGES−1) performs these steps:
  - adds chunk k, i.e. bits [k·W+W−1 : k·W], using the carry registered by stage k−1 (stage 0 uses the effective C_in);
  - writes the chunk sum into the stage k result register, alongside the already-resolved lower chunks;
  - forwards the unresolved upper operand chunks unchanged (skew buffer).
- The ~B inversion is applied once, at input capture.
- Each stage holds a valid bit. The last stage drives out_valid, S_out, C_out and ovf directly from registers; there is no combinational path from A/B to the outputs.
- Flow control uses a global enable:
  - en = !out_valid || out_ready;
  - in_ready = en;
  - when en=1, every stage advances, and bubbles advance as bubbles;
  - when en=0, every stage and output holds.
- Transfers:
  - an input word is accepted on an edge where in_valid && in_ready;
  - a result is consumed on an edge where out_valid && out_ready.
- Results leave in acceptance order. None are dropped or duplicated.
- STAGES=1 degenerates to a single registered n-bit add with a 1-cycle latency.

## Timing
- Reset, asserted asynchronously:
  - all stage valid bits go to 0, out_valid=0 and in_ready=1;
  - S_out, C_out, ovf and all data registers go to 0;
  - operations in flight are discarded.
- Reset is released synchronously to the design. The first accept is possible on the first edge after release.
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+STAGES, provided en stays 1. Each cycle of en=0 adds one cycle of latency.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous accept and consume in the same cycle is legal and required for full throughput.
- While out_valid=1 and out_ready=0:
  - S_out, C_out and ovf stay stable;
  - in_ready=0;
  - A, B, C_in and sub are ignored.
- in_valid=0 with en=1 inserts a bubble. out_valid goes low STAGES cycles later for exactly one cycle.
- in_ready depends only on out_valid and out_ready, never on in_valid.

## Test plan
All scenarios use n=16 and STAGES=4.
1. Add, basic: A=0x0005, B=0x000F, C_in=1, sub=0, out_ready=1 → S_out=0x0015, C_out=0, ovf=0, with out_valid high exactly 4 cycles after accept.
2. Full-width carry ripple: A=0xFFFF, B=0x0001, C_in=0 → S_out=0x0000, C_out=1, ovf=0. Also A=0xFFFF, B=0xFFFF, C_in=1 → S_out=0xFFFF, C_out=1, ovf=0.
3. Signed overflow: A=0x7FFF, B=0x0001, C_in=0 → S_out=0x8000, C_out=0, ovf=1. Also A=0x8000, B=0x8000 → S_out=0x0000, C_out=1, ovf=1.
4. Subtract: sub=1, C_in=1, A=0x0003, B=0x0005 → S_out=0xFFFE, C_out=0, ovf=0. Also A=0x0005, B=0x0003 → S_out=0x0002, C_out=1.
5. Backpressure and ordering:
   - stimulus: 10 back-to-back words with random A/B/sub, out_ready deasserted for 3 cycles mid-stream;
   - response: in_ready=0 during exactly those cycles, outputs stable, all 10 results match a reference model in order, no loss or duplication;
   - repeat with a random in_valid gap pattern.
6. Reset mid-stream: assert rst with 3 words in flight and out_valid=1 → out_valid=0, S_out=0, C_out=0, ovf=0 before the next edge. After release, no stale result appears, and a new word returns its result 4 cycles after accept.

Source files
------------

// File: rtl/pipe_rca_addsub.sv
// rtl/pipe_rca_addsub.sv - pipelined ripple-carry adder/subtractor with valid/ready flow control
module pipe_rca_addsub #(
  parameter int n      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         C_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] S_out,
  output logic         C_out,
  output logic         ovf
);

  localparam int W = n / STAGES;

  // Index 0 is the input capture register; index k+1 holds the result of stage k.
  // Operand skew buffers are only needed up to the last stage's input.
  logic         v_q [0:STAGES];
  logic [n-1:0] s_q [0:STAGES];
  logic         c_q [0:STAGES];
  logic [n-1:0] a_q [0:STAGES-1];
  logic [n-1:0] b_q [0:STAGES-1];
  logic         ovf_q;

  logic [n-1:0] s_nx [0:STAGES-1];
  logic         c_nx [0:STAGES-1];
  logic         ovf_nx;
  logic [W:0]   chunk;
  logic         en;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[STAGES];
  assign S_out     = s_q[STAGES];
  assign C_out     = c_q[STAGES];
  assign ovf       = ovf_q;

  // Per-stage chunk add: stage k resolves bits [k*W +: W] with the carry from stage k-1.
  always_comb begin
    chunk  = '0;
    ovf_nx = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      chunk   = {1'b0, a_q[k][k*W +: W]} + {1'b0, b_q[k][k*W +: W]} + {{W{1'b0}}, c_q[k]};
      s_nx[k] = s_q[k];
      s_nx[k][k*W +: W] = chunk[W-1:0];
      c_nx[k] = chunk[W];
    end
    // Carry into the MSB is recovered as a^b^sum at bit n-1 of the last stage.
    ovf_nx = a_q[STAGES-1][n-1] ^ b_q[STAGES-1][n-1] ^ s_nx[STAGES-1][n-1] ^ c_nx[STAGES-1];
  end

  // Pipeline registers: capture (with B inversion for subtract), skew buffers, partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_q[k] <= 1'b0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q[0] <= in_valid;
      a_q[0] <= A;
      b_q[0] <= sub ? ~B : B;
      c_q[0] <= C_in;
      s_q[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        v_q[k+1] <= v_q[k];
        s_q[k+1] <= s_nx[k];
        c_q[k+1] <= c_nx[k];
      end
      ovf_q <= ovf_nx;
    end
  end

endmodule
